// File: rtl/proc_param.sv
// W-bit multicycle lab processor: eight registers, accumulator A, result G, one-hot bus,
// 9-bit instructions from DIN under a Run/Done handshake, with N/Z/C status flags.
module proc_param #(
    parameter int W = 16
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [W-1:0] DIN,
    input  logic         Run,
    output logic         Done,
    output logic [W-1:0] BusWires,
    output logic [2:0]   Flags
);

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_MVNZ = 3'b101;

    // Bus source select bits: [7:0] registers, [8] G, [9] DIN
    localparam int SEL_G   = 8;
    localparam int SEL_DIN = 9;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_t;

    step_t        step;
    step_t        step_nxt;
    logic [W-1:0] r [8];
    logic [W-1:0] a;
    logic [W-1:0] g;
    logic [8:0]   ir;
    logic [2:0]   flags;

    logic [2:0]   opcode;
    logic [7:0]   x_oh;
    logic [7:0]   y_oh;
    logic [7:0]   rin;
    logic         ain;
    logic         gin;
    logic [9:0]   sel;
    logic         done;
    logic [W-1:0] bus;
    logic [W+2:0] alu_out;

    // Result is {N, Z, C, value}; sub uses A + ~B + 1 so C means "no borrow"
    function automatic logic [W+2:0] alu(input logic [2:0] op,
                                         input logic [W-1:0] lhs,
                                         input logic [W-1:0] rhs);
        logic [W:0]   sum;
        logic [W-1:0] res;
        logic         carry;
        sum   = '0;
        res   = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                sum   = {1'b0, lhs} + {1'b0, rhs};
                res   = sum[W-1:0];
                carry = sum[W];
            end
            OP_SUB: begin
                sum   = {1'b0, lhs} + {1'b0, ~rhs} + {{W{1'b0}}, 1'b1};
                res   = sum[W-1:0];
                carry = sum[W];
            end
            default: begin
                res   = lhs & rhs;
                carry = 1'b0;
            end
        endcase
        return {res[W-1], (res == '0), carry, res};
    endfunction

    assign opcode = ir[8:6];
    assign x_oh   = 8'b0000_0001 << ir[5:3];
    assign y_oh   = 8'b0000_0001 << ir[2:0];

    always_comb begin
        step_nxt = step;
        rin      = 8'b0;
        ain      = 1'b0;
        gin      = 1'b0;
        sel      = 10'b0;
        done     = 1'b0;
        case (step)
            T0: begin
                step_nxt = Run ? T1 : T0;
            end
            T1: begin
                case (opcode)
                    OP_MV: begin
                        sel[7:0] = y_oh;
                        rin      = x_oh;
                        done     = 1'b1;
                    end
                    OP_MVI: begin
                        sel[SEL_DIN] = 1'b1;
                        rin          = x_oh;
                        done         = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND: begin
                        sel[7:0] = x_oh;
                        ain      = 1'b1;
                    end
                    OP_MVNZ: begin
                        sel[7:0] = y_oh;
                        rin      = flags[1] ? 8'b0 : x_oh;
                        done     = 1'b1;
                    end
                    default: begin
                        done = 1'b1;
                    end
                endcase
                step_nxt = done ? T0 : T2;
            end
            T2: begin
                sel[7:0] = y_oh;
                gin      = 1'b1;
                step_nxt = T3;
            end
            T3: begin
                sel[SEL_G] = 1'b1;
                rin        = x_oh;
                done       = 1'b1;
                step_nxt   = T0;
            end
            default: begin
                step_nxt = T0;
            end
        endcase
    end

    // One-hot AND-OR bus; no source selected yields zero
    always_comb begin
        bus = '0;
        for (int i = 0; i < 8; i++) begin
            if (sel[i]) begin
                bus = bus | r[i];
            end
        end
        if (sel[SEL_G]) begin
            bus = bus | g;
        end
        if (sel[SEL_DIN]) begin
            bus = bus | DIN;
        end
    end

    assign alu_out = alu(opcode, a, bus);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            step  <= T0;
            ir    <= '0;
            a     <= '0;
            g     <= '0;
            flags <= 3'b000;
            for (int i = 0; i < 8; i++) begin
                r[i] <= '0;
            end
        end else begin
            step <= step_nxt;
            if (step == T0 && Run) begin
                ir <= DIN[8:0];
            end
            for (int i = 0; i < 8; i++) begin
                if (rin[i]) begin
                    r[i] <= bus;
                end
            end
            if (ain) begin
                a <= bus;
            end
            if (gin) begin
                g     <= alu_out[W-1:0];
                flags <= alu_out[W+2:W];
            end
        end
    end

    assign Done     = done;
    assign BusWires = bus;
    assign Flags    = flags;

endmodule

// File: tb/tb_proc_param.sv
// Directed bench for proc_param: instruction sequences with hand-computed register,
// flag, bus and Done-timing expectations.
module tb_proc_param;

    localparam int W = 16;

    localparam logic [2:0] MV   = 3'b000;
    localparam logic [2:0] MVI  = 3'b001;
    localparam logic [2:0] ADD  = 3'b010;
    localparam logic [2:0] SUB  = 3'b011;
    localparam logic [2:0] AND_ = 3'b100;
    localparam logic [2:0] MVNZ = 3'b101;
    localparam logic [2:0] NOP0 = 3'b110;
    localparam logic [2:0] NOP1 = 3'b111;

    logic         Clock;
    logic         Reset;
    logic [W-1:0] DIN;
    logic         Run;
    logic         Done;
    logic [W-1:0] BusWires;
    logic [2:0]   Flags;

    int           n_tests = 0;
    int           n_fail  = 0;
    int           done_at;
    logic [W-1:0] bus_log [1:6];
    logic [W-1:0] v;
    logic [8:0]   seq [1:8];
    logic [7:0]   done_mask;
    logic [W-1:0] bus_c2;
    logic [W-1:0] bus_c8;

    proc_param #(.W(W)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .DIN      (DIN),
        .Run      (Run),
        .Done     (Done),
        .BusWires (BusWires),
        .Flags    (Flags)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] enc(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y);
        return {op, x, y};
    endfunction

    // Cycle 1 is T0 with Run=1; later cycles drive imm on DIN until Done (bounded)
    task automatic run_instr(input logic [8:0] ins, input logic [W-1:0] imm);
        done_at = 0;
        for (int k = 1; k <= 6; k++) bus_log[k] = '0;
        @(negedge Clock);
        Run = 1'b1;
        DIN = {{(W-9){1'b0}}, ins};
        #1;
        bus_log[1] = BusWires;
        if (Done) done_at = 1;
        for (int k = 2; k <= 6 && done_at == 0; k++) begin
            @(negedge Clock);
            Run = 1'b0;
            DIN = imm;
            #1;
            bus_log[k] = BusWires;
            if (Done) done_at = k;
        end
        Run = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] n, output logic [W-1:0] val);
        run_instr(enc(MV, n, n), '0);
        val = bus_log[2];
    endtask

    initial begin
        Reset = 1'b1;
        Run   = 1'b0;
        DIN   = '0;
        repeat (2) @(negedge Clock);
        Reset = 1'b0;

        // Idle after reset
        for (int k = 0; k < 5; k++) begin
            @(negedge Clock);
            #1;
            check("idle_done", Done, 0);
            check("idle_bus", BusWires, 0);
            check("idle_flags", Flags, 3'b000);
            check("idle_step", dut.step, 0);
        end
        run_instr(enc(MV, 3'd1, 3'd0), '0);
        check("mv_r1_r0_done", done_at, 2);
        read_reg(3'd1, v);
        check("r1_after_reset", v, 16'h0000);

        // Signed overflow on add
        run_instr(enc(MVI, 3'd0, 3'd0), 16'h7FFF);
        check("mvi_done", done_at, 2);
        run_instr(enc(MVI, 3'd1, 3'd0), 16'h0001);
        run_instr(enc(ADD, 3'd0, 3'd1), '0);
        check("add_done_cycle", done_at, 4);
        check("add_t1_bus_rx", bus_log[2], 16'h7FFF);
        check("add_t2_bus_ry", bus_log[3], 16'h0001);
        check("add_t3_bus_g", bus_log[4], 16'h8000);
        check("add_flags", Flags, 3'b100);
        read_reg(3'd0, v);
        check("add_r0", v, 16'h8000);

        // sub to zero, then mvnz blocked and allowed
        run_instr(enc(MVI, 3'd3, 3'd0), 16'hAAAA);
        run_instr(enc(MVI, 3'd2, 3'd0), 16'h0005);
        run_instr(enc(SUB, 3'd2, 3'd2), '0);
        check("sub_done_cycle", done_at, 4);
        check("sub_flags", Flags, 3'b011);
        read_reg(3'd2, v);
        check("sub_r2", v, 16'h0000);
        run_instr(enc(MVNZ, 3'd3, 3'd2), '0);
        check("mvnz_z1_done", done_at, 2);
        read_reg(3'd3, v);
        check("mvnz_z1_r3_kept", v, 16'hAAAA);
        run_instr(enc(MVI, 3'd4, 3'd0), 16'h0001);
        check("mvi_keeps_flags", Flags, 3'b011);
        run_instr(enc(AND_, 3'd4, 3'd4), '0);
        check("and_done_cycle", done_at, 4);
        check("and_r4_flags", Flags, 3'b000);
        run_instr(enc(MVNZ, 3'd3, 3'd4), '0);
        check("mvnz_z0_done", done_at, 2);
        read_reg(3'd3, v);
        check("mvnz_z0_r3", v, 16'h0001);

        // Unsigned wrap-around and and-clears-carry
        run_instr(enc(MVI, 3'd5, 3'd0), 16'hFFFF);
        run_instr(enc(MVI, 3'd6, 3'd0), 16'h0001);
        run_instr(enc(ADD, 3'd5, 3'd6), '0);
        check("wrap_flags", Flags, 3'b011);
        read_reg(3'd5, v);
        check("wrap_r5", v, 16'h0000);
        run_instr(enc(AND_, 3'd5, 3'd6), '0);
        check("and_c0_flags", Flags, 3'b010);
        run_instr(enc(NOP0, 3'd5, 3'd6), '0);
        check("nop110_done", done_at, 2);
        check("nop110_flags", Flags, 3'b010);
        read_reg(3'd5, v);
        check("nop110_r5", v, 16'h0000);

        // Reset during T2 of add R0,R1
        run_instr(enc(MVI, 3'd0, 3'd0), 16'h0003);
        run_instr(enc(MVI, 3'd1, 3'd0), 16'h0004);
        @(negedge Clock);
        Run = 1'b1;
        DIN = {{(W-9){1'b0}}, enc(ADD, 3'd0, 3'd1)};
        #1;
        check("abort_t0_done", Done, 0);
        @(negedge Clock);
        Run = 1'b0;
        DIN = '0;
        #1;
        check("abort_t1_done", Done, 0);
        @(negedge Clock);
        Reset = 1'b1;
        #1;
        check("abort_t2_done", Done, 0);
        check("abort_t2_step", dut.step, 2);
        @(negedge Clock);
        Reset = 1'b0;
        #1;
        check("abort_step_t0", dut.step, 0);
        check("abort_g", dut.g, 16'h0000);
        check("abort_no_done", Done, 0);
        check("abort_flags", Flags, 3'b000);
        read_reg(3'd0, v);
        check("abort_r0", v, 16'h0000);
        read_reg(3'd1, v);
        check("abort_r1", v, 16'h0000);

        // Run held high across mv, nop, sub
        run_instr(enc(MVI, 3'd1, 3'd0), 16'h0009);
        run_instr(enc(MVI, 3'd2, 3'd0), 16'h0003);
        seq[1] = enc(MV, 3'd3, 3'd1);
        seq[2] = enc(MV, 3'd3, 3'd1);
        seq[3] = enc(NOP1, 3'd0, 3'd0);
        seq[4] = enc(NOP1, 3'd0, 3'd0);
        for (int k = 5; k <= 8; k++) seq[k] = enc(SUB, 3'd1, 3'd2);
        done_mask = '0;
        bus_c2    = '0;
        bus_c8    = '0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge Clock);
            Run = 1'b1;
            DIN = {{(W-9){1'b0}}, seq[k]};
            #1;
            done_mask[k-1] = Done;
            if (k == 2) bus_c2 = BusWires;
            if (k == 8) bus_c8 = BusWires;
        end
        Run = 1'b0;
        check("b2b_done_pattern", done_mask, 8'b1000_1010);
        check("b2b_mv_bus_ry", bus_c2, 16'h0009);
        check("b2b_sub_bus_g", bus_c8, 16'h0006);
        check("b2b_sub_flags", Flags, 3'b001);
        read_reg(3'd3, v);
        check("b2b_r3", v, 16'h0009);
        read_reg(3'd1, v);
        check("b2b_r1", v, 16'h0006);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/proc_param.md
# proc_param

Parametrised successor to the 9-bit multicycle processor: a W-bit datapath with eight general registers, accumulator A, result register G and a common bus. It executes 9-bit instructions fetched from DIN under a Run/Done handshake. Beyond mv/mvi/add/sub it adds bitwise AND, a conditional move, a NOP, and an N/Z/C status register. It sits in the same lab-processor hierarchy and is driven by a testbench or a program-memory sequencer.

## Interface
- W, 16, datapath width; legal range 9..32, since the instruction is taken from DIN[8:0].
- Clock  input  1  rising-edge clock for all state.
- Reset  input  1  synchronous, active-high; clears all state at the next rising edge.
- DIN  input  W  instruction in T0 (bits [8:0]); immediate operand for mvi in T1.
- Run  input  1  start request; sampled only in T0.
- Done  output  1  combinational; high in the final step of each instruction.
- BusWires  output  W  common bus value.
- Flags  output  3  {N,Z,C}, registered.

## Operation
- Instruction format IR[8:0] = III XXX YYY. X and Y are decoded one-hot to select registers R0..R7.
- Opcodes:
  - 000 mv: Rx <= Ry.
  - 001 mvi: Rx <= DIN.
  - 010 add: Rx <= Rx + Ry.
  - 011 sub: Rx <= Rx - Ry.
  - 100 and: Rx <= Rx & Ry.
  - 101 mvnz: Rx <= Ry only if Z == 0.
  - 110 and 111: nop.
- Step counter states T0..T3, 2-bit.
  - T0: if Run, IR <= DIN[8:0] and go to T1; otherwise hold IR and stay in T0.
  - T1, mv: bus = Ry, Rin = X, Done.
  - T1, mvi: bus = DIN, Rin = X, Done.
  - T1, mvnz: bus = Ry, Rin = X only if Z == 0; Done in either case.
  - T1, nop: Done, no writes.
  - T1, add/sub/and: bus = Rx, Ain.
  - T2, add/sub/and: bus = Ry, G <= ALU(A, bus), flags <= ALU flags.
  - T3, add/sub/and: bus = G, Rin = X, Done.
  - Transitions: T1 goes to T0 when Done, else to T2. T2 goes to T3. T3 goes to T0.
- Bus select is one-hot over {R0..R7, G, DIN}. When no source is selected (T0, T2 of nothing), bus = 0.
- ALU arithmetic is modulo 2^W.
  - add: C = carry-out of A + B.
  - sub: computed as A + ~B + 1; C = carry-out (1 = no borrow).
  - and: C = 0.
  - Z = (result == 0); N = result[W-1].
- Flags change only in T2 of add, sub or and. mv, mvi, mvnz and nop leave the flags unchanged.
- Rx == Ry is legal for every opcode. add R0,R0 doubles R0, and sub R0,R0 gives 0 with Z=1, C=1.
- Run is ignored outside T0. Holding Run high back-to-back fetches a new instruction every T0.

## Timing
- Reset values: step = T0; R0..R7, A, G, IR = 0; Flags = 3'b000. Done = 0 and BusWires = 0, since T0 selects no source.
- Reset asserted in any step takes effect at the next edge:
  - the in-flight instruction is abandoned with no register write;
  - the edge on which Reset is high does not perform the pending Rin/Gin write.
- Reset has priority over Run.
- Register writes (Rx, A, G, Flags, IR) occur on the rising edge that ends the step.
  - A destination written in T1 or T3 is visible on BusWires from the following step onward.
- Latency counted from the T0 edge that samples Run=1:
  - mv, mvi, mvnz, nop: Done in the next cycle; 2 cycles per instruction.
  - add, sub, and: Done in the third following cycle; 4 cycles per instruction.
- Done is high for exactly one cycle per instruction and is never high in T0 or T2.
- mvi samples DIN during its T1 cycle. The instruction word and the immediate are therefore presented in consecutive cycles.
- The 2-bit step counter cannot wrap outside T0..T3. The IR opcode space is fully decoded.

## Test plan
- Reset, then idle with Run=0 for 5 cycles:
  - Done=0, BusWires=0, Flags=000, and the step stays in T0;
  - mv R1,R0 then reads back 0.
- W=16; mvi R0,#0x7FFF; mvi R1,#0x0001; add R0,R1:
  - Done at cycle 4 of the add;
  - R0=0x8000, Flags N=1, Z=0, C=0.
- mvi R2,#5; sub R2,R2:
  - R2=0, Z=1, C=1, N=0;
  - a following mvnz R3,R2 leaves R3 unchanged (Done still asserted);
  - after mvi R4,#1; and R4,R4 (Z=0), mvnz R3,R4 writes R3=1.
- mvi R5,#0xFFFF; mvi R6,#0x0001; add R5,R6:
  - R5=0, C=1, Z=1 (wrap-around);
  - and R5,R6 afterwards gives C=0.
- Assert Reset during T2 of add R0,R1 with R0=3, R1=4:
  - the next cycle is T0 with R0=0 and G=0;
  - no Done pulse occurs for the aborted instruction.
- Run held high across mv, nop, sub back-to-back:
  - Done pulses at cycles 2, 4 and 8;
  - BusWires shows Ry during the T1 of mv and G during the T3 of sub.
